// File: rtl/vga_pattern_sequencer_if.sv
// Control and VGA DAC-side signals of the test-pattern sequencer.
// The slave modport is the sequencer's view; master is the driving/monitoring side.
interface vga_pattern_sequencer_if;
  logic       iAUTO;
  logic       iNEXT;
  logic [9:0] oRed;
  logic [9:0] oGreen;
  logic [9:0] oBlue;
  logic       oVGA_HS;
  logic       oVGA_VS;
  logic       oVGA_BLANK;
  logic [9:0] oVGA_X;
  logic [9:0] oVGA_Y;
  logic       oFRAME_START;
  logic [1:0] oPAT;

  modport master (
    output iAUTO, iNEXT,
    input  oRed, oGreen, oBlue, oVGA_HS, oVGA_VS, oVGA_BLANK,
    input  oVGA_X, oVGA_Y, oFRAME_START, oPAT
  );

  modport slave (
    input  iAUTO, iNEXT,
    output oRed, oGreen, oBlue, oVGA_HS, oVGA_VS, oVGA_BLANK,
    output oVGA_X, oVGA_Y, oFRAME_START, oPAT
  );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// 640x480@60 raster generator with four test patterns switched only at frame boundaries.
// Optional white one-pixel border around the active area: define VGA_PATTERN_BORDER_EN.
module vga_pattern_sequencer #(
  parameter int DWELL_FRAMES = 120,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic                    iVGA_CLK,
  input  logic                    iRST,
  vga_pattern_sequencer_if.slave  vga
);

  localparam logic [9:0]  H_ACT_L    = 10'(H_ACT);
  localparam logic [9:0]  V_ACT_L    = 10'(V_ACT);
  localparam logic [9:0]  H_LAST     = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  HS_START   = 10'(H_ACT + H_FP);
  localparam logic [9:0]  HS_END     = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START   = 10'(V_ACT + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACT + V_FP + V_SYNC);
  localparam logic [11:0] DWELL_LAST = 12'(DWELL_FRAMES - 1);
  localparam logic [9:0]  FULL       = 10'd1023;

  typedef enum logic {IDLE_MANUAL = 1'b0, AUTO = 1'b1} sched_state_t;

  sched_state_t state, state_next;
  logic [9:0]   h, v;
  logic [1:0]   pat, pat_next;
  logic         pending, pending_next;
  logic [11:0]  dwell, dwell_next;
  logic         frame_end, expire, advance;
  logic         active;
  logic [2:0]   bar_idx;
  logic [9:0]   red, green, blue;

  assign frame_end = (h == H_LAST) && (v == V_LAST);
  assign active    = (h < H_ACT_L) && (v < V_ACT_L);
  assign bar_idx   = 3'(h / 10'd80);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      state   <= IDLE_MANUAL;
      pat     <= '0;
      pending <= 1'b0;
      dwell   <= '0;
    end else begin
      state   <= state_next;
      pat     <= pat_next;
      pending <= pending_next;
      dwell   <= dwell_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = vga.iAUTO ? AUTO : IDLE_MANUAL;
    pat_next     = pat;
    pending_next = pending | vga.iNEXT;
    dwell_next   = dwell;
    expire       = (state == AUTO) && (dwell == DWELL_LAST);
    advance      = 1'b0;

    if (frame_end) begin
      // A request landing on the boundary cycle is consumed here, never carried over.
      advance      = pending | vga.iNEXT | expire;
      pending_next = 1'b0;
      if (state == AUTO) dwell_next = dwell + 12'd1;
    end

    if (advance) pat_next = pat + 2'd1;
    if (advance || state_next == IDLE_MANUAL) dwell_next = '0;
  end

  always_comb begin
    red   = '0;
    green = '0;
    blue  = '0;
    if (active) begin
      unique case (pat)
        2'd0: red = 10'd512;
        2'd1: begin
          red   = {10{bar_idx[2]}};
          green = {10{bar_idx[1]}};
          blue  = {10{bar_idx[0]}};
        end
        2'd2: begin
          red   = {10{h[5] ^ v[5]}};
          green = red;
          blue  = red;
        end
        default: begin
          red   = h;
          green = v;
          blue  = FULL - h;
        end
      endcase
`ifdef VGA_PATTERN_BORDER_EN
      if (h == '0 || h == H_ACT_L - 10'd1 || v == '0 || v == V_ACT_L - 10'd1) begin
        red   = FULL;
        green = FULL;
        blue  = FULL;
      end
`endif
    end
  end

  // Everything leaves through one register stage so RGB, syncs and coordinates stay aligned.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      vga.oRed         <= '0;
      vga.oGreen       <= '0;
      vga.oBlue        <= '0;
      vga.oVGA_HS      <= 1'b1;
      vga.oVGA_VS      <= 1'b1;
      vga.oVGA_BLANK   <= 1'b1;
      vga.oVGA_X       <= '0;
      vga.oVGA_Y       <= '0;
      vga.oFRAME_START <= 1'b0;
      vga.oPAT         <= '0;
    end else begin
      vga.oRed         <= red;
      vga.oGreen       <= green;
      vga.oBlue        <= blue;
      vga.oVGA_HS      <= !((h >= HS_START) && (h < HS_END));
      vga.oVGA_VS      <= !((v >= VS_START) && (v < VS_END));
      vga.oVGA_BLANK   <= !active;
      vga.oVGA_X       <= h;
      vga.oVGA_Y       <= v;
      vga.oFRAME_START <= (h == '0) && (v == '0);
      vga.oPAT         <= pat;
    end
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench for vga_pattern_sequencer on a shrunken raster so many frames fit in a short run.
// Raster timing is scoreboarded every cycle; pattern values come from a vector table.
module tb_vga_pattern_sequencer;

  localparam int H_ACT = 88, H_FP = 2, H_SYNC = 4, H_BP = 2;
  localparam int V_ACT = 34, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
`ifdef VGA_PATTERN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_pattern_sequencer_if vga ();

  vga_pattern_sequencer #(
    .DWELL_FRAMES(2),
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .iVGA_CLK(clk),
    .iRST(rst),
    .vga(vga)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Raster scoreboard: expected output pushed at each edge, popped on the following falling edge.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
  } raster_t;

  raster_t rq[$];
  int      line_err = 0;

  initial begin : raster_model
    raster_t e;
    int mh, mv;
    mh = 0;
    mv = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        e  = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b1, fs: 1'b0};
        mh = 0;
        mv = 0;
      end else begin
        e.x     = 10'(mh);
        e.y     = 10'(mv);
        e.hs    = !(mh >= H_ACT + H_FP && mh < H_ACT + H_FP + H_SYNC);
        e.vs    = !(mv >= V_ACT + V_FP && mv < V_ACT + V_FP + V_SYNC);
        e.blank = !(mh < H_ACT && mv < V_ACT);
        e.fs    = (mh == 0 && mv == 0);
        mh++;
        if (mh == H_TOT) begin
          mh = 0;
          mv = (mv == V_TOT - 1) ? 0 : mv + 1;
        end
      end
      rq.push_back(e);
    end
  end

  initial begin : raster_check
    raster_t e;
    forever begin
      @(negedge clk);
      if (rq.size() > 0) begin
        e = rq.pop_front();
        if (vga.oVGA_X !== e.x || vga.oVGA_Y !== e.y || vga.oVGA_HS !== e.hs ||
            vga.oVGA_VS !== e.vs || vga.oVGA_BLANK !== e.blank || vga.oFRAME_START !== e.fs)
          line_err++;
        if (e.blank && {vga.oRed, vga.oGreen, vga.oBlue} !== 30'd0) line_err++;
        if (e.x == 10'(H_TOT - 1)) begin
          check($sformatf("raster_line_y%0d_bad_cycles", e.y), line_err, 0);
          line_err = 0;
        end
      end
    end
  end

  // Pattern scoreboard: expected oPAT for each upcoming frame, checked on oFRAME_START.
  logic [1:0] pq[$];

  initial begin : pattern_check
    forever begin
      @(negedge clk);
      if (vga.oFRAME_START === 1'b1 && pq.size() > 0) check("frame_pat", vga.oPAT, pq.pop_front());
    end
  end

  typedef struct {
    int         pat;
    int         x;
    int         y;
    bit         on_edge;
    logic [9:0] r, g, b;
  } vec_t;

  vec_t vecs[15];

  task automatic wait_pixel(input int x, input int y, input int pat);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
      hit = (vga.oVGA_X == 10'(x)) && (vga.oVGA_Y == 10'(y)) && (pat < 0 || vga.oPAT == 2'(pat));
    end
    if (!hit) check($sformatf("pixel_reached_%0d_%0d", x, y), 32'(hit), 1);
  endtask

  task automatic wait_pq(input int k);
    int n;
    n = 0;
    while (pq.size() > k && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (pq.size() > k) check("frame_starts_seen", pq.size(), k);
  endtask

  task automatic count_until(input bit vsync, input logic lvl, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((vsync ? vga.oVGA_VS : vga.oVGA_HS) !== lvl) && n < 3 * FRAME);
  endtask

  task automatic pulse_next();
    vga.iNEXT = 1'b1;
    @(negedge clk);
    vga.iNEXT = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_red"}, vga.oRed, 0);
    check({tag, "_green"}, vga.oGreen, 0);
    check({tag, "_blue"}, vga.oBlue, 0);
    check({tag, "_hs"}, vga.oVGA_HS, 1);
    check({tag, "_vs"}, vga.oVGA_VS, 1);
    check({tag, "_blank"}, vga.oVGA_BLANK, 1);
    check({tag, "_x"}, vga.oVGA_X, 0);
    check({tag, "_y"}, vga.oVGA_Y, 0);
    check({tag, "_fs"}, vga.oFRAME_START, 0);
    check({tag, "_pat"}, vga.oPAT, 0);
  endtask

  task automatic check_first_pixel(input string tag);
    check({tag, "_x"}, vga.oVGA_X, 0);
    check({tag, "_y"}, vga.oVGA_Y, 0);
    check({tag, "_fs"}, vga.oFRAME_START, 1);
    check({tag, "_pat"}, vga.oPAT, 0);
    check({tag, "_blank"}, vga.oVGA_BLANK, 0);
    check({tag, "_red"}, vga.oRed, BORDER ? 1023 : 512);
    check({tag, "_green"}, vga.oGreen, BORDER ? 1023 : 0);
  endtask

  initial begin : main
    int n, low, high;
    logic [9:0] er, eg, eb;

    //            pat  x   y  edge   R     G     B
    vecs[0]  = '{0,  10, 10, 0,  512,    0,    0};
    vecs[1]  = '{0,  90, 10, 0,    0,    0,    0};
    vecs[2]  = '{0,   0, 20, 1,  512,    0,    0};
    vecs[3]  = '{0,  87, 33, 1,  512,    0,    0};
    vecs[4]  = '{0,  10, 35, 0,    0,    0,    0};
    vecs[5]  = '{1,  10,  5, 0,    0,    0,    0};
    vecs[6]  = '{1,  85,  5, 0,    0,    0, 1023};
    vecs[7]  = '{2,  32,  0, 1, 1023, 1023, 1023};
    vecs[8]  = '{2,  33,  1, 0, 1023, 1023, 1023};
    vecs[9]  = '{2,   5, 32, 0, 1023, 1023, 1023};
    vecs[10] = '{2,  32, 32, 0,    0,    0,    0};
    vecs[11] = '{2,  10, 35, 0,    0,    0,    0};
    vecs[12] = '{3,   0,  0, 1,    0,    0, 1023};
    vecs[13] = '{3,  40, 20, 0,   40,   20,  983};
    vecs[14] = '{3,  87, 33, 1,   87,   33,  936};

    vga.iAUTO = 1'b0;
    vga.iNEXT = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_first_pixel("release");

    count_until(1'b0, 1'b0, n);
    count_until(1'b0, 1'b1, low);
    count_until(1'b0, 1'b0, high);
    check("hs_low_cycles", low, H_SYNC);
    check("hs_period", low + high, H_TOT);
    count_until(1'b1, 1'b0, n);
    count_until(1'b1, 1'b1, low);
    count_until(1'b1, 1'b0, high);
    check("vs_low_cycles", low, V_SYNC * H_TOT);
    check("vs_period", low + high, FRAME);

    // Auto mode with a two-frame dwell, pattern table checked while it cycles.
    vga.iAUTO = 1'b1;
    pq.push_back(2'd0); pq.push_back(2'd1); pq.push_back(2'd1); pq.push_back(2'd2);
    pq.push_back(2'd2); pq.push_back(2'd3); pq.push_back(2'd3); pq.push_back(2'd0);
    foreach (vecs[i]) begin
      wait_pixel(vecs[i].x, vecs[i].y, vecs[i].pat);
      er = vecs[i].r;
      eg = vecs[i].g;
      eb = vecs[i].b;
      if (BORDER && vecs[i].on_edge) begin
        er = 10'd1023;
        eg = 10'd1023;
        eb = 10'd1023;
      end
      check($sformatf("p%0d_red_%0d_%0d", vecs[i].pat, vecs[i].x, vecs[i].y), vga.oRed, er);
      check($sformatf("p%0d_green_%0d_%0d", vecs[i].pat, vecs[i].x, vecs[i].y), vga.oGreen, eg);
      check($sformatf("p%0d_blue_%0d_%0d", vecs[i].pat, vecs[i].x, vecs[i].y), vga.oBlue, eb);
    end
    wait_pq(0);

    // Brief iAUTO drop clears the dwell count; then iNEXT lands on an expiring boundary.
    pq.push_back(2'd0); pq.push_back(2'd0); pq.push_back(2'd1); pq.push_back(2'd1);
    wait_pq(3);
    wait_pixel(20, 10, -1);
    vga.iAUTO = 1'b0;
    repeat (3) @(negedge clk);
    vga.iAUTO = 1'b1;
    wait_pq(2);
    wait_pixel(H_TOT - 2, V_TOT - 1, -1);
    pulse_next();
    wait_pq(0);
    vga.iAUTO = 1'b0;

    // Manual: request on the boundary cycle advances once and is not carried forward.
    pq.push_back(2'd2); pq.push_back(2'd2);
    wait_pixel(H_TOT - 2, V_TOT - 1, -1);
    pulse_next();
    wait_pq(0);

    // Manual: mid-frame request holds the pattern until the next frame.
    wait_pixel(50, 20, -1);
    pulse_next();
    wait_pixel(10, 30, -1);
    check("hold_mid_frame_pat", vga.oPAT, 2);
    pq.push_back(2'd3);
    wait_pq(0);

    // Reset mid-frame restarts the raster at pixel (0,0) with pattern 0.
    wait_pixel(30, 20, -1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_first_pixel("mid_release");
    repeat (2 * H_TOT) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
